// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the max-pool reader and its feature-map RAM.
// It holds the FSM state encoding, the default image geometry, the address
// widths, and the signed max helper.
package cnn_pkg;

  localparam int IMG_H = 28;
  localparam int IMG_W = 28;
  localparam int OH    = IMG_H - 2;
  localparam int OW    = IMG_W - 2;
  localparam int PH    = OH / 2;
  localparam int PW    = OW / 2;

  localparam int FMAP_AW = 10;
  localparam int POOL_AW = 8;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_R0   = 3'd1,
    S_R1   = 3'd2,
    S_R2   = 3'd3,
    S_R3   = 3'd4,
    S_CMP  = 3'd5,
    S_EMIT = 3'd6,
    S_DONE = 3'd7
  } state_t;

  // Max of two 32-bit two's-complement words.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// fmap_ram: feature-map buffer with one synchronous write port and one
// synchronous read port. The read data appears one cycle after the address.
// Ports:
//   clk          - clock
//   i_we/i_waddr/i_wdata - write port
//   i_raddr      - read address, registered on the rising edge
//   o_rdata      - read data, valid one cycle after i_raddr
module fmap_ram
  import cnn_pkg::*;
#(
  parameter int DEPTH = OH * OW
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [FMAP_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [FMAP_AW-1:0] i_raddr,
  output logic [DATA_W-1:0]  o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // There is no reset. The contents survive reset and readout.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/maxpool_reader.sv
// maxpool_reader: captures the conv output stream into a local buffer.
// On conv_done it reads the buffer back as non-overlapping 2x2 windows and
// emits one signed-max + ReLU word per window.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   store/address/result           - feature-map write stream (IDLE only)
//   conv_done                      - start readout (IDLE only)
//   pool_result/pool_address       - registered pooled word and its address
//   pool_store                     - one-cycle valid pulse for the pooled word
//   pool_done                      - one-cycle pulse after the last word
//   busy                           - high whenever the state is not IDLE
//
// state  | meaning
// IDLE   | accept writes, wait for conv_done
// R0     | read window word a0
// R1     | read a1, max <- d0
// R2     | read a2, max <- smax(max, d1)
// R3     | read a3, max <- smax(max, d2)
// CMP    | fold d3, load pooled output registers
// EMIT   | pool_store high, advance (pi, pj)
// DONE   | pool_done high, return to IDLE
module maxpool_reader
  import cnn_pkg::*;
#(
  parameter int H = IMG_H,
  parameter int W = IMG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               store,
  input  logic [FMAP_AW-1:0] address,
  input  logic [DATA_W-1:0]  result,
  input  logic               conv_done,
  output logic [DATA_W-1:0]  pool_result,
  output logic [POOL_AW-1:0] pool_address,
  output logic               pool_store,
  output logic               pool_done,
  output logic               busy
);

  localparam int C_OH    = H - 2;
  localparam int C_OW    = W - 2;
  localparam int C_PH    = C_OH / 2;
  localparam int C_PW    = C_OW / 2;
  localparam int C_DEPTH = C_OH * C_OW;

  state_t             r_state;
  logic [FMAP_AW-1:0] r_pi;
  logic [FMAP_AW-1:0] r_pj;
  logic [DATA_W-1:0]  r_max;

  logic               w_we;
  logic [FMAP_AW-1:0] w_base;
  logic [FMAP_AW-1:0] w_raddr;
  logic [DATA_W-1:0]  w_rdata;
  logic [DATA_W-1:0]  w_max_final;
  logic [POOL_AW-1:0] w_pool_addr;
  logic               w_last_col;
  logic               w_last_row;

  assign w_we = !rst && (r_state == S_IDLE) && store &&
                (address < FMAP_AW'(C_DEPTH));

  assign w_base      = FMAP_AW'(2 * r_pi * C_OW + 2 * r_pj);
  assign w_pool_addr = POOL_AW'(r_pi * C_PW + r_pj);
  assign w_last_col  = (r_pj == FMAP_AW'(C_PW - 1));
  assign w_last_row  = (r_pi == FMAP_AW'(C_PH - 1));
  assign w_max_final = smax(r_max, w_rdata);

  always_comb begin
    w_raddr = w_base;
    case (r_state)
      S_R1:    w_raddr = w_base + FMAP_AW'(1);
      S_R2:    w_raddr = w_base + FMAP_AW'(C_OW);
      S_R3:    w_raddr = w_base + FMAP_AW'(C_OW + 1);
      default: w_raddr = w_base;
    endcase
  end

  fmap_ram #(
    .DEPTH (C_DEPTH)
  ) u_fmap_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (address),
    .i_wdata (result),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pi         <= '0;
      r_pj         <= '0;
      r_max        <= '0;
      pool_result  <= '0;
      pool_address <= '0;
      pool_store   <= 1'b0;
      pool_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (conv_done) begin
            r_state <= S_R0;
            r_pi    <= '0;
            r_pj    <= '0;
            busy    <= 1'b1;
          end
        end
        S_R0: r_state <= S_R1;
        S_R1: begin
          r_max   <= w_rdata;
          r_state <= S_R2;
        end
        S_R2: begin
          r_max   <= w_max_final;
          r_state <= S_R3;
        end
        S_R3: begin
          r_max   <= w_max_final;
          r_state <= S_CMP;
        end
        S_CMP: begin
          // Load the outputs here so that pool_store is high exactly while
          // the state is EMIT.
          r_max        <= w_max_final;
          pool_result  <= w_max_final[DATA_W-1] ? '0 : w_max_final;
          pool_address <= w_pool_addr;
          pool_store   <= 1'b1;
          r_state      <= S_EMIT;
        end
        S_EMIT: begin
          pool_store <= 1'b0;
          if (w_last_col) begin
            r_pj <= '0;
            r_pi <= r_pi + FMAP_AW'(1);
          end else begin
            r_pj <= r_pj + FMAP_AW'(1);
          end
          if (w_last_col && w_last_row) begin
            r_state   <= S_DONE;
            pool_done <= 1'b1;
          end else begin
            r_state <= S_R0;
          end
        end
        S_DONE: begin
          pool_done <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
